// File: rtl/regfile_if.sv
// Decoder/ROB-facing bundle of the rename register file: two read ports,
// one rename port, one commit port, flush, global enable and busy count.
interface regfile_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
);
    logic              rdy;
    logic [4:0]        rs1_idx;
    logic [DATA_W-1:0] rs1_data;
    logic [TAG_W-1:0]  rs1_tag;
    logic [4:0]        rs2_idx;
    logic [DATA_W-1:0] rs2_data;
    logic [TAG_W-1:0]  rs2_tag;
    logic              rename_en;
    logic [4:0]        rename_rd;
    logic [TAG_W-1:0]  rename_tag;
    logic              if_commit;
    logic [4:0]        pos_commit;
    logic [DATA_W-1:0] data_commit;
    logic [TAG_W-1:0]  tag_commit;
    logic              clear_reg;
    logic [5:0]        busy_cnt;

    // Decoder/ROB side
    modport master (
        output rdy, rs1_idx, rs2_idx,
        output rename_en, rename_rd, rename_tag,
        output if_commit, pos_commit, data_commit, tag_commit, clear_reg,
        input  rs1_data, rs1_tag, rs2_data, rs2_tag, busy_cnt
    );

    // Register file side
    modport slave (
        input  rdy, rs1_idx, rs2_idx,
        input  rename_en, rename_rd, rename_tag,
        input  if_commit, pos_commit, data_commit, tag_commit, clear_reg,
        output rs1_data, rs1_tag, rs2_data, rs2_tag, busy_cnt
    );
endinterface

// File: rtl/regfile.sv
// Architectural register file with per-register ROB rename tags.
// A nonzero tag means the register value is still owned by an in-flight
// ROB entry; commits write data and release the tag only if the committing
// entry is still the youngest owner.
module regfile #(
    parameter int                DATA_W    = 32,
    parameter int                TAG_W     = 5,
    parameter logic [TAG_W-1:0]  EMPTY_TAG = '0
) (
    input  logic      clk,
    input  logic      rst,
    regfile_if.slave  bus
);

    logic [DATA_W-1:0] data_q [32];
    logic [TAG_W-1:0]  tag_q  [32];
    logic [TAG_W-1:0]  tag_nxt [32];
    logic [5:0]        busy_q;
    logic [5:0]        busy_nxt;

    logic commit_do;
    logic rename_do;
    logic rs1_byp;
    logic rs2_byp;

    // x0 is never written; a flush suppresses the rename but not the commit
    assign commit_do = bus.rdy && bus.if_commit && (bus.pos_commit != 5'd0);
    assign rename_do = bus.rdy && bus.rename_en && (bus.rename_rd != 5'd0) && !bus.clear_reg;

    // A commit whose tag still owns the source register forwards its value
    assign rs1_byp = bus.if_commit && (bus.pos_commit == bus.rs1_idx) &&
                     (bus.rs1_idx != 5'd0) && (tag_q[bus.rs1_idx] == bus.tag_commit);
    assign rs2_byp = bus.if_commit && (bus.pos_commit == bus.rs2_idx) &&
                     (bus.rs2_idx != 5'd0) && (tag_q[bus.rs2_idx] == bus.tag_commit);

    assign bus.rs1_data = (bus.rs1_idx == 5'd0) ? '0 :
                          rs1_byp ? bus.data_commit : data_q[bus.rs1_idx];
    assign bus.rs1_tag  = (bus.rs1_idx == 5'd0 || rs1_byp) ? EMPTY_TAG : tag_q[bus.rs1_idx];
    assign bus.rs2_data = (bus.rs2_idx == 5'd0) ? '0 :
                          rs2_byp ? bus.data_commit : data_q[bus.rs2_idx];
    assign bus.rs2_tag  = (bus.rs2_idx == 5'd0 || rs2_byp) ? EMPTY_TAG : tag_q[bus.rs2_idx];
    assign bus.busy_cnt = busy_q;

    // Next tag array: flush clears all, otherwise release then rename (rename wins)
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            tag_nxt[i[4:0]] = tag_q[i[4:0]];
        end
        if (bus.rdy) begin
            if (bus.clear_reg) begin
                for (int i = 0; i < 32; i++) begin
                    tag_nxt[i[4:0]] = EMPTY_TAG;
                end
            end else begin
                if (commit_do && (tag_q[bus.pos_commit] == bus.tag_commit)) begin
                    tag_nxt[bus.pos_commit] = EMPTY_TAG;
                end
                if (rename_do) begin
                    tag_nxt[bus.rename_rd] = bus.rename_tag;
                end
            end
        end
        tag_nxt[0] = EMPTY_TAG;
    end

    // Busy count is the population of nonzero next-state tags, so it nets
    // rename and release, drops to 0 on flush and stays within 0..31
    always_comb begin
        busy_nxt = 6'd0;
        for (int i = 1; i < 32; i++) begin
            busy_nxt = busy_nxt + {5'd0, (tag_nxt[i[4:0]] != EMPTY_TAG)};
        end
    end

    // Data array: committed values land regardless of tag ownership or flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                data_q[i[4:0]] <= '0;
            end
        end else if (commit_do) begin
            data_q[bus.pos_commit] <= bus.data_commit;
        end
    end

    // Tag array and busy count: reset discards every pending rename
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                tag_q[i[4:0]] <= EMPTY_TAG;
            end
            busy_q <= 6'd0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                tag_q[i[4:0]] <= tag_nxt[i[4:0]];
            end
            busy_q <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for the rename register file: expected read/busy values
// are queued alongside each stimulus and compared when the outputs settle.
module tb_regfile;

    logic clk;
    logic rst;

    regfile_if #(.DATA_W(32), .TAG_W(5)) bus ();

    regfile #(.DATA_W(32), .TAG_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    string       sb_name [$];
    int          sb_kind [$];
    logic [31:0] sb_val  [$];

    localparam int K_RS1D = 0;
    localparam int K_RS1T = 1;
    localparam int K_RS2D = 2;
    localparam int K_RS2T = 3;
    localparam int K_BUSY = 4;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic sb_push(input string name, input int kind, input logic [31:0] val);
        sb_name.push_back(name);
        sb_kind.push_back(kind);
        sb_val.push_back(val);
    endtask

    task automatic drain();
        string       nm;
        int          k;
        logic [31:0] v;
        logic [31:0] got;
        while (sb_kind.size() > 0) begin
            nm = sb_name.pop_front();
            k  = sb_kind.pop_front();
            v  = sb_val.pop_front();
            case (k)
                K_RS1D:  got = bus.rs1_data;
                K_RS1T:  got = {27'd0, bus.rs1_tag};
                K_RS2D:  got = bus.rs2_data;
                K_RS2T:  got = {27'd0, bus.rs2_tag};
                default: got = {26'd0, bus.busy_cnt};
            endcase
            check(nm, got, v);
        end
    endtask

    task automatic idle();
        bus.rdy         = 1'b1;
        bus.rename_en   = 1'b0;
        bus.rename_rd   = 5'd0;
        bus.rename_tag  = 5'd0;
        bus.if_commit   = 1'b0;
        bus.pos_commit  = 5'd0;
        bus.data_commit = 32'd0;
        bus.tag_commit  = 5'd0;
        bus.clear_reg   = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rename(input logic [4:0] rd, input logic [4:0] tg);
        idle();
        bus.rename_en  = 1'b1;
        bus.rename_rd  = rd;
        bus.rename_tag = tg;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [4:0] tg, input logic [31:0] d);
        bus.if_commit   = 1'b1;
        bus.pos_commit  = rd;
        bus.tag_commit  = tg;
        bus.data_commit = d;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        bus.rs1_idx = 5'd5;
        bus.rs2_idx = 5'd0;
        repeat (2) @(negedge clk);
        #1;
        sb_push("rst_rs1_data", K_RS1D, 32'd0);
        sb_push("rst_rs1_tag",  K_RS1T, 32'd0);
        sb_push("rst_busy",     K_BUSY, 32'd0);
        drain();
        @(negedge clk);
        rst = 1'b0;

        // Rename then commit on x5; same-cycle read sees pre-rename tag
        rename(5'd5, 5'd3);
        bus.rs1_idx = 5'd5;
        #1;
        sb_push("ren_same_cycle_tag", K_RS1T, 32'd0);
        drain();
        step();
        idle();
        #1;
        sb_push("ren_x5_tag",  K_RS1T, 32'd3);
        sb_push("ren_x5_busy", K_BUSY, 32'd1);
        drain();
        commit(5'd5, 5'd3, 32'hDEADBEEF);
        #1;
        sb_push("byp_x5_data", K_RS1D, 32'hDEADBEEF);
        sb_push("byp_x5_tag",  K_RS1T, 32'd0);
        sb_push("byp_x5_busy", K_BUSY, 32'd1);
        drain();
        step();
        idle();
        #1;
        sb_push("cmt_x5_data", K_RS1D, 32'hDEADBEEF);
        sb_push("cmt_x5_tag",  K_RS1T, 32'd0);
        sb_push("cmt_x5_busy", K_BUSY, 32'd0);
        drain();

        // Stale commit on x7: younger tag 4 must survive
        rename(5'd7, 5'd2);
        step();
        rename(5'd7, 5'd4);
        step();
        idle();
        commit(5'd7, 5'd2, 32'h11);
        bus.rs1_idx = 5'd7;
        #1;
        sb_push("stale_no_byp_data", K_RS1D, 32'd0);
        sb_push("stale_no_byp_tag",  K_RS1T, 32'd4);
        drain();
        step();
        idle();
        #1;
        sb_push("stale_x7_data", K_RS1D, 32'h11);
        sb_push("stale_x7_tag",  K_RS1T, 32'd4);
        sb_push("stale_busy",    K_BUSY, 32'd1);
        drain();

        // Same-cycle rename and commit on x9
        rename(5'd9, 5'd6);
        step();
        idle();
        bus.rs2_idx = 5'd9;
        #1;
        sb_push("x9_pre_busy", K_BUSY, 32'd2);
        drain();
        rename(5'd9, 5'd8);
        commit(5'd9, 5'd6, 32'h22);
        step();
        idle();
        #1;
        sb_push("rc_x9_data", K_RS2D, 32'h22);
        sb_push("rc_x9_tag",  K_RS2T, 32'd8);
        sb_push("rc_busy",    K_BUSY, 32'd2);
        drain();

        // Flush with commit and dropped rename
        bus.clear_reg = 1'b1;
        step();
        idle();
        #1;
        sb_push("flush0_busy", K_BUSY, 32'd0);
        drain();
        rename(5'd1, 5'd1);
        step();
        rename(5'd2, 5'd2);
        step();
        rename(5'd3, 5'd3);
        step();
        idle();
        #1;
        sb_push("pre_flush_busy", K_BUSY, 32'd3);
        drain();
        rename(5'd4, 5'd9);
        commit(5'd1, 5'd1, 32'h55);
        bus.clear_reg = 1'b1;
        step();
        idle();
        bus.rs1_idx = 5'd1;
        bus.rs2_idx = 5'd4;
        #1;
        sb_push("flush_x1_data", K_RS1D, 32'h55);
        sb_push("flush_x1_tag",  K_RS1T, 32'd0);
        sb_push("flush_x4_tag",  K_RS2T, 32'd0);
        sb_push("flush_busy",    K_BUSY, 32'd0);
        drain();
        bus.rs1_idx = 5'd2;
        bus.rs2_idx = 5'd3;
        #1;
        sb_push("flush_x2_tag", K_RS1T, 32'd0);
        sb_push("flush_x3_tag", K_RS2T, 32'd0);
        drain();

        // x0 writes ignored
        rename(5'd0, 5'd5);
        commit(5'd0, 5'd0, 32'hFF);
        bus.rs1_idx = 5'd0;
        #1;
        sb_push("x0_comb_data", K_RS1D, 32'd0);
        drain();
        step();
        idle();
        #1;
        sb_push("x0_data", K_RS1D, 32'd0);
        sb_push("x0_tag",  K_RS1T, 32'd0);
        sb_push("x0_busy", K_BUSY, 32'd0);
        drain();

        // rdy low holds state
        commit(5'd2, 5'd0, 32'h77);
        step();
        idle();
        bus.rdy = 1'b0;
        rename(5'd2, 5'd7);
        bus.rdy = 1'b0;
        commit(5'd2, 5'd0, 32'h99);
        step();
        idle();
        bus.rs2_idx = 5'd2;
        #1;
        sb_push("rdy0_x2_data", K_RS2D, 32'h77);
        sb_push("rdy0_x2_tag",  K_RS2T, 32'd0);
        sb_push("rdy0_busy",    K_BUSY, 32'd0);
        drain();

        // Asynchronous reset with three tags pending
        rename(5'd10, 5'd1);
        step();
        rename(5'd11, 5'd2);
        step();
        rename(5'd12, 5'd3);
        step();
        idle();
        bus.rs1_idx = 5'd1;
        bus.rs2_idx = 5'd10;
        #1;
        sb_push("prerst_x1_data", K_RS1D, 32'h55);
        sb_push("prerst_x10_tag", K_RS2T, 32'd1);
        sb_push("prerst_busy",    K_BUSY, 32'd3);
        drain();
        #2;
        rst = 1'b1;
        #1;
        sb_push("arst_x1_data",  K_RS1D, 32'd0);
        sb_push("arst_x1_tag",   K_RS1T, 32'd0);
        sb_push("arst_x10_data", K_RS2D, 32'd0);
        sb_push("arst_x10_tag",  K_RS2T, 32'd0);
        sb_push("arst_busy",     K_BUSY, 32'd0);
        drain();
        @(negedge clk);
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameters: DATA_W = 32, data width; TAG_W = 5, ROB tag width; EMPTY_TAG = 0, means "value valid in regfile".
REQ-002 clk  in  1  the only clock; all state updates on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 rdy  in  1  global enable; when low, no state changes.
REQ-005 rs1_idx  in  5  decoder source-1 register index.
REQ-006 rs1_data  out  32  source-1 value, combinational.
REQ-007 rs1_tag  out  TAG_W  source-1 pending ROB tag; 0 means rs1_data is valid.
REQ-008 rs2_idx, rs2_data, rs2_tag  in/out/out  5/32/TAG_W  same as REQ-005..007 for source 2.
REQ-009 rename_en  in  1  decoder dispatches an instruction that writes rename_rd.
REQ-010 rename_rd  in  5  destination register index.
REQ-011 rename_tag  in  TAG_W  ROB entry allocated to that instruction.
REQ-012 if_commit  in  1  ROB commit strobe.
REQ-013 pos_commit  in  5  committed destination register.
REQ-014 data_commit  in  32  committed value.
REQ-015 tag_commit  in  TAG_W  ROB entry being committed.
REQ-016 clear_reg  in  1  misprediction flush from the ROB.
REQ-017 busy_cnt  out  6  registered count of registers with a nonzero tag.

Function
REQ-018 State: 32 x 32-bit data array and 32 x TAG_W tag array; x0 data and tag are always 0.
REQ-019 Read, combinational: idx 0 -> data 0, tag 0.
REQ-020 Read bypass: if if_commit, pos_commit == idx != 0, and stored tag == tag_commit, the port returns data_commit with tag 0 in the same cycle.
REQ-021 Reads never reflect a same-cycle rename; a source equal to rename_rd sees the pre-rename tag and data.
REQ-022 Commit (rdy, if_commit, pos_commit != 0): data[pos_commit] <= data_commit unconditionally.
REQ-023 Commit tag release: tag[pos_commit] <= 0 only if the stored tag == tag_commit and no same-cycle rename targets pos_commit; otherwise the tag is kept, because a younger writer owns it.
REQ-024 Rename (rdy, rename_en, rename_rd != 0, !clear_reg): tag[rename_rd] <= rename_tag; data is untouched.
REQ-025 Same register renamed and committed in one cycle: data <= data_commit, tag <= rename_tag.
REQ-026 Writes to x0, by rename or by commit, are ignored with no state or busy_cnt change.
REQ-027 Flush (rdy, clear_reg): all tags <= 0 and same-cycle renames are dropped.
REQ-028 A commit in the flush cycle still writes its data, since the ROB asserts commit together with clear on jalr.
REQ-029 busy_cnt update: +1 when a rename sets a previously zero tag; -1 when a commit releases a tag; net of both in one cycle; 0 after a flush.
REQ-030 busy_cnt range: never exceeds 31 and never underflows.
REQ-031 rdy low: data, tags and busy_cnt hold; combinational read ports stay live.
REQ-032 Latency: a committed value is visible on reads in the same cycle through the bypass, and from the array on the next cycle.
REQ-033 Latency: a renamed tag is visible on reads from the next cycle.

Reset
REQ-034 While rst is high, asynchronously: all data <= 0, all tags <= 0, busy_cnt <= 0.
REQ-035 Inputs are ignored during reset; normal operation starts on the first rising edge after rst deasserts.
REQ-036 Reset asserted mid-operation discards every pending rename, so all reads return tag 0 with data 0.

Verification
REQ-037 Rename then commit:
- Stimulus: rename x5 tag 3; next cycle read rs1_idx=5; then commit pos 5 / tag 3 / data 0xDEADBEEF.
- Response: read gives tag 3; the commit cycle bypass gives data 0xDEADBEEF with tag 0; tag is 0 afterwards; busy_cnt goes 1 -> 0.
REQ-038 Stale commit: rename x7 tag 2, then rename x7 tag 4, then commit x7 tag 2 data 0x11. Response: data = 0x11, tag stays 4, busy_cnt stays 1.
REQ-039 Same-cycle rename and commit on x9: stored tag 6; commit tag 6 data 0x22 and rename tag 8 in one cycle. Response: data 0x22, tag 8, busy_cnt unchanged.
REQ-040 Flush with commit:
- Setup: x1, x2, x3 renamed; busy_cnt = 3.
- Stimulus: clear_reg with commit x1 data 0x55 and rename x4 tag 9.
- Response: all tags 0, x1 = 0x55, x4 not renamed, busy_cnt = 0.
REQ-041 x0 and rdy:
- x0 case: rename x0 tag 5 and commit x0 data 0xFF. Response: reads of x0 give 0 / tag 0, busy_cnt = 0.
- rdy case: rdy=0 with a commit to x2. Response: no change.
REQ-042 Asynchronous reset: raise rst between clock edges with 3 tags pending. Response: all outputs 0 before the next edge.
